// File: rtl/data_bus_bridge_pkg.sv
// bridge_pkg: shared constants and types for the data-side bus bridge.
// Holds the IO register offsets, the STATUS word layout and the posted-write entry type.
// No logic of its own; the status_word helper is a pure function.
package bridge_pkg;

  localparam int IO_AW_DEF = 12;

  // IO register offsets within the IO region
  localparam logic [11:0] STATUS_OFF  = 12'hFFC;
  localparam logic [11:0] PUSHCNT_OFF = 12'hFF4;
  localparam logic [11:0] DROPCNT_OFF = 12'hFF8;

  // STATUS word bit positions
  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_CNT_LSB   = 8;
  localparam int ST_CNT_W     = 8;
  localparam int ST_OVF_BIT   = 31;

  // One posted IO write: offset in the upper bits, store data in the lower 32
  typedef struct packed {
    logic [IO_AW_DEF-1:0] addr;
    logic [31:0]          data;
  } io_entry_t;

  // Assemble the STATUS read value; every unused bit reads 0
  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic [ST_CNT_W-1:0] cnt,
                                              input logic ovf);
    logic [31:0] w;
    w = 32'h0;
    w[ST_EMPTY_BIT] = empty;
    w[ST_FULL_BIT]  = full;
    w[ST_CNT_LSB +: ST_CNT_W] = cnt;
    w[ST_OVF_BIT]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/data_bus_bridge_sync_fifo.sv
// sync_fifo: generic registered FIFO with explicit occupancy counter.
// Latency: a push is visible at dout_o/!empty_o one cycle after the edge it is written.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [W-1:0]                 din_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         push_ok_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign do_pop    = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push   = push_i & (~full_o | do_pop);
  assign push_ok_o = do_push;
  assign count_o   = cnt_q;
  assign dout_o    = mem_q[rd_q];

  // Next-state for pointers (wrap by power-of-2 overflow) and occupancy
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: routes core data accesses to RAM or posts IO stores into a drain FIFO.
// Latency: RAM path and ReadData combinational; posted IO write appears on io_valid 1 cycle later.
// Backpressure: none toward the core; IO stores hitting a full FIFO are dropped and set irq_overflow.
// Build option DATA_BUS_BRIDGE_STATS_EN adds push/drop counters at offsets 0xFF4/0xFF8.
module data_bus_bridge
  import bridge_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IO_REGION  = 4'hF,
  parameter int         IO_AW      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  input  logic             MemWrite,
  output logic [31:0]      ReadData,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic             ram_we,
  input  logic [31:0]      ram_rdata,
  output logic             io_valid,
  input  logic             io_ready,
  output logic [IO_AW-1:0] io_addr,
  output logic [31:0]      io_wdata,
  output logic             irq_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = IO_AW + 32;

  logic             is_io, hit_status, hit_stats;
  logic [IO_AW-1:0] off;
  logic             push_req, push_ok, drop, status_clr;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [EW-1:0]    fifo_dout;
  logic             ovf_q, ovf_d;

  assign is_io      = (Address[31:28] == IO_REGION);
  assign off        = Address[IO_AW-1:0];
  assign hit_status = (off == IO_AW'(STATUS_OFF));

`ifdef DATA_BUS_BRIDGE_STATS_EN
  assign hit_stats  = (off == IO_AW'(PUSHCNT_OFF)) | (off == IO_AW'(DROPCNT_OFF));
`else
  assign hit_stats  = 1'b0;
`endif

  // RAM side is a straight pass-through gated only by region
  assign ram_addr   = Address;
  assign ram_wdata  = WriteData;
  assign ram_we     = MemWrite & ~is_io;

  assign push_req   = MemWrite & is_io & ~hit_status & ~hit_stats;
  assign drop       = push_req & ~push_ok;
  assign status_clr = MemWrite & is_io & hit_status & WriteData[31];

  // Entry layout matches io_entry_t: offset above data
  sync_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_req),
    .din_i     ({off, WriteData}),
    .pop_i     (io_ready),
    .dout_o    (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt),
    .push_ok_o (push_ok)
  );

  assign io_valid     = ~fifo_empty;
  assign io_addr      = fifo_dout[EW-1:32];
  assign io_wdata     = fifo_dout[31:0];
  assign irq_overflow = ovf_q;

  // Sticky overflow: a drop in the same cycle as a clear keeps it set
  always_comb begin
    ovf_d = ovf_q;
    if (drop)            ovf_d = 1'b1;
    else if (status_clr) ovf_d = 1'b0;
  end

  // Overflow register
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

`ifdef DATA_BUS_BRIDGE_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        stats_clr;

  assign stats_clr = MemWrite & is_io & hit_stats;

  // Wrapping event counters; a store to either counter offset zeroes both
  always_comb begin
    push_cnt_d = push_cnt_q + {31'b0, push_ok};
    drop_cnt_d = drop_cnt_q + {31'b0, drop};
    if (stats_clr) begin
      push_cnt_d = 32'h0;
      drop_cnt_d = 32'h0;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      push_cnt_q <= 32'h0;
      drop_cnt_q <= 32'h0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  // Load mux: RAM data, STATUS, optional counters, otherwise zero
  always_comb begin
    ReadData = 32'h0;
    if (!is_io) begin
      ReadData = ram_rdata;
    end else if (hit_status) begin
      ReadData = status_word(fifo_empty, fifo_full, ST_CNT_W'(fifo_cnt), ovf_q);
`ifdef DATA_BUS_BRIDGE_STATS_EN
    end else if (off == IO_AW'(PUSHCNT_OFF)) begin
      ReadData = push_cnt_q;
    end else if (off == IO_AW'(DROPCNT_OFF)) begin
      ReadData = drop_cnt_q;
`endif
    end
  end

endmodule
